// File: rtl/pipe_sequencer_pkg.sv
// Shared types and sizing for the in-order issue sequencer.
package pipe_sequencer_pkg;

  localparam int unsigned PC_W     = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned SB_DEPTH = 2;
  localparam int unsigned ICNT_W   = 5;
  localparam int unsigned SCNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STALL,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One in-flight write tracked by the scoreboard.
  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dest;
  } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes plus the RAW hazard compare.
module hazard_scoreboard #(
  parameter int unsigned SB_DEPTH = pipe_sequencer_pkg::SB_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               shift_en,
  input  logic                               clr,
  input  logic                               ins_valid,
  input  logic                               ins_wr,
  input  logic [pipe_sequencer_pkg::REG_W-1:0] ins_dest,
  input  logic [pipe_sequencer_pkg::REG_W-1:0] op_reg1,
  input  logic [pipe_sequencer_pkg::REG_W-1:0] op_reg2,
  input  logic                               imm_or_reg,
  output logic                               hazard_c,
  output logic                               drain_empty_c
);
  import pipe_sequencer_pkg::*;

  sb_slot_t [SB_DEPTH-1:0] slots_q;
  sb_slot_t [SB_DEPTH-1:0] slots_d;
  sb_slot_t                new_slot;

  // Next slot contents: new write enters slot0, older entries age by one.
  always_comb begin
    new_slot       = '0;
    new_slot.valid = ins_valid;
    new_slot.wr    = ins_valid & ins_wr;
    new_slot.dest  = ins_valid ? ins_dest : '0;
    slots_d        = slots_q;
    if (clr) begin
      slots_d = '0;
    end else if (shift_en) begin
      for (int i = int'(SB_DEPTH) - 1; i > 0; i--) begin
        slots_d[i] = slots_q[i-1];
      end
      slots_d[0] = new_slot;
    end
  end

  // Hazard on any pending write to a source register; drain is complete once
  // only the oldest slot can still hold an entry (it falls out on this shift).
  always_comb begin
    hazard_c      = 1'b0;
    drain_empty_c = 1'b1;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (slots_q[i].valid && slots_q[i].wr &&
          ((slots_q[i].dest == op_reg1) ||
           (!imm_or_reg && (slots_q[i].dest == op_reg2)))) begin
        hazard_c = 1'b1;
      end
    end
    for (int i = 0; i < int'(SB_DEPTH) - 1; i++) begin
      if (slots_q[i].valid) begin
        drain_empty_c = 1'b0;
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

endmodule

// File: rtl/pipe_sequencer.sv
// In-order issue sequencer: fetch PC, stall on RAW hazards, drain, report done.
module pipe_sequencer #(
  parameter int unsigned PC_W     = pipe_sequencer_pkg::PC_W,
  parameter int unsigned SB_DEPTH = pipe_sequencer_pkg::SB_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  halt,
  input  logic [PC_W-1:0]                       last_pc,
  input  logic [pipe_sequencer_pkg::REG_W-1:0]  dec_op_reg1,
  input  logic [pipe_sequencer_pkg::REG_W-1:0]  dec_op_reg2,
  input  logic [pipe_sequencer_pkg::REG_W-1:0]  dec_dest,
  input  logic                                  dec_imm_or_reg,
  input  logic                                  dec_wr_en,
  output logic [PC_W-1:0]                       PC,
  output logic                                  issue_valid,
  output logic                                  bubble,
  output logic                                  busy,
  output logic                                  done,
  output logic [pipe_sequencer_pkg::ICNT_W-1:0] issue_cnt,
  output logic [pipe_sequencer_pkg::SCNT_W-1:0] stall_cnt
);
  import pipe_sequencer_pkg::*;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              issue_valid_q, issue_valid_d;
  logic              bubble_q, bubble_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;

  logic issue_c;
  logic launch_c;
  logic sb_shift_c;
  logic hazard_c;
  logic drain_empty_c;

  hazard_scoreboard #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .shift_en      (sb_shift_c),
    .clr           (launch_c),
    .ins_valid     (issue_c),
    .ins_wr        (dec_wr_en),
    .ins_dest      (dec_dest),
    .op_reg1       (dec_op_reg1),
    .op_reg2       (dec_op_reg2),
    .imm_or_reg    (dec_imm_or_reg),
    .hazard_c      (hazard_c),
    .drain_empty_c (drain_empty_c)
  );

  // Next-state, issue/bubble decision and counter updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    icnt_d     = icnt_q;
    scnt_d     = scnt_q;
    issue_c    = 1'b0;
    bubble_d   = 1'b0;
    launch_c   = 1'b0;
    sb_shift_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (start) launch_c = 1'b1;
      end
      ST_RUN, ST_STALL: begin
        sb_shift_c = 1'b1;
        if (halt) begin
          state_d = ST_DRAIN;
        end else if (hazard_c) begin
          bubble_d = 1'b1;
          state_d  = ST_STALL;
          if (scnt_q != {SCNT_W{1'b1}}) scnt_d = scnt_q + SCNT_W'(1);
        end else begin
          issue_c = 1'b1;
          icnt_d  = icnt_q + ICNT_W'(1);
          if (pc_q == last_pc) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        sb_shift_c = 1'b1;
        if (drain_empty_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) launch_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A launch restarts the program with a clean scoreboard and counters.
    if (launch_c) begin
      state_d = ST_RUN;
      pc_d    = '0;
      icnt_d  = '0;
      scnt_d  = '0;
    end

    issue_valid_d = issue_c;
    busy_d        = (state_d == ST_RUN) || (state_d == ST_STALL) || (state_d == ST_DRAIN);
    done_d        = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      issue_valid_q <= 1'b0;
      bubble_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      icnt_q        <= '0;
      scnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_valid_q <= issue_valid_d;
      bubble_q      <= bubble_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      icnt_q        <= icnt_d;
      scnt_q        <= scnt_d;
    end
  end

  assign PC          = pc_q;
  assign issue_valid = issue_valid_q;
  assign bubble      = bubble_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_cnt   = icnt_q;
  assign stall_cnt   = scnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: program table plus reset/halt sequences.
module tb_pipe_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       halt;
  logic [3:0] last_pc;
  logic [3:0] dec_op_reg1, dec_op_reg2, dec_dest;
  logic       dec_imm_or_reg, dec_wr_en;
  logic [3:0] PC;
  logic       issue_valid, bubble, busy, done;
  logic [4:0] issue_cnt;
  logic [7:0] stall_cnt;

  logic [3:0] prog_r1   [16];
  logic [3:0] prog_r2   [16];
  logic [3:0] prog_dest [16];
  logic       prog_imm  [16];
  logic       prog_wr   [16];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0][3:0] r1;
    logic [3:0][3:0] r2;
    logic [3:0][3:0] dest;
    logic [3:0]      imm;
    logic [3:0]      wr;
    logic [3:0]      last_pc;
    logic            halt_en;
    logic [3:0]      halt_pc;
    int              exp_issue;
    int              exp_stall;
    int              exp_edges;
  } vec_t;

  vec_t vecs[8];

  pipe_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .last_pc        (last_pc),
    .dec_op_reg1    (dec_op_reg1),
    .dec_op_reg2    (dec_op_reg2),
    .dec_dest       (dec_dest),
    .dec_imm_or_reg (dec_imm_or_reg),
    .dec_wr_en      (dec_wr_en),
    .PC             (PC),
    .issue_valid    (issue_valid),
    .bubble         (bubble),
    .busy           (busy),
    .done           (done),
    .issue_cnt      (issue_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: decode fields follow the fetch address.
  assign dec_op_reg1    = prog_r1[PC];
  assign dec_op_reg2    = prog_r2[PC];
  assign dec_dest       = prog_dest[PC];
  assign dec_imm_or_reg = prog_imm[PC];
  assign dec_wr_en      = prog_wr[PC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, 32'(PC), 0);
    chk({tag, "_issue_valid"}, 32'(issue_valid), 0);
    chk({tag, "_bubble"}, 32'(bubble), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_issue_cnt"}, 32'(issue_cnt), 0);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
  endtask

  task automatic load_prog(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      prog_r1[i]   = 4'd14;
      prog_r2[i]   = 4'd15;
      prog_dest[i] = 4'd13;
      prog_imm[i]  = 1'b0;
      prog_wr[i]   = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      prog_r1[i]   = v.r1[i];
      prog_r2[i]   = v.r2[i];
      prog_dest[i] = v.dest[i];
      prog_imm[i]  = v.imm[i];
      prog_wr[i]   = v.wr[i];
    end
    last_pc = v.last_pc;
  endtask

  task automatic wait_done(input string tag);
    int edges;
    edges = 0;
    while (done !== 1'b1 && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_done_reached"}, 32'(done), 1);
  endtask

  task automatic run_vec(input int k);
    vec_t       v;
    int         edges, n_iss, n_bub, last_iss;
    logic [3:0] pc_b;
    bit         seen;
    v = vecs[k];
    load_prog(v);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d_launch_busy", k), 32'(busy), 1);
    chk($sformatf("v%0d_launch_pc", k), 32'(PC), 0);
    chk($sformatf("v%0d_launch_cnt", k), 32'({issue_cnt, stall_cnt}), 0);
    edges = 0; n_iss = 0; n_bub = 0; last_iss = 0; seen = 1'b0;
    while (!seen && edges < 64) begin
      @(negedge clk);
      start = 1'b0;
      halt  = v.halt_en && (PC == v.halt_pc);
      pc_b  = PC;
      @(posedge clk); #1;
      edges++;
      if (issue_valid) begin
        chk($sformatf("v%0d_issue_pc", k), 32'(pc_b), 32'(n_iss));
        n_iss++;
        last_iss = edges;
      end
      if (bubble) n_bub++;
      if (done) seen = 1'b1;
    end
    halt = 1'b0;
    chk($sformatf("v%0d_done_edges", k), 32'(edges), 32'(v.exp_edges));
    chk($sformatf("v%0d_issue_cnt", k), 32'(issue_cnt), 32'(v.exp_issue));
    chk($sformatf("v%0d_stall_cnt", k), 32'(stall_cnt), 32'(v.exp_stall));
    chk($sformatf("v%0d_bubbles_seen", k), 32'(n_bub), 32'(v.exp_stall));
    chk($sformatf("v%0d_done_after_last_issue", k), 32'(edges - last_iss), 2);
    chk($sformatf("v%0d_busy_at_done", k), 32'(busy), 0);
  endtask

  initial begin
    // Baseline: independent program reading R1/R2, writing R8..R11.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        vecs[k].r1[i]   = 4'd1;
        vecs[k].r2[i]   = 4'd2;
        vecs[k].dest[i] = 4'(8 + i);
      end
      vecs[k].imm       = 4'b0000;
      vecs[k].wr        = 4'b1111;
      vecs[k].last_pc   = 4'd3;
      vecs[k].halt_en   = 1'b0;
      vecs[k].halt_pc   = 4'd0;
      vecs[k].exp_issue = 4;
      vecs[k].exp_stall = 0;
      vecs[k].exp_edges = 6;
    end
    // v1: PC0 writes R4, PC1 reads R4 on op_reg1
    vecs[1].dest[0] = 4'd4; vecs[1].r1[1] = 4'd4;
    vecs[1].exp_stall = 2; vecs[1].exp_edges = 8;
    // v2: PC0 writes R4, PC2 reads R4 on op_reg2
    vecs[2].dest[0] = 4'd4; vecs[2].r2[2] = 4'd4;
    vecs[2].exp_stall = 1; vecs[2].exp_edges = 7;
    // v3: match only on op_reg2 but immediate form
    vecs[3].dest[0] = 4'd4; vecs[3].r2[1] = 4'd4; vecs[3].imm[1] = 1'b1;
    // v4: dest matches but producer does not write
    vecs[4].dest[0] = 4'd4; vecs[4].wr[0] = 1'b0; vecs[4].r1[1] = 4'd4;
    // v5: halt while PC=2
    vecs[5].halt_en = 1'b1; vecs[5].halt_pc = 4'd2;
    vecs[5].exp_issue = 2; vecs[5].exp_edges = 4;
    // v6: chained dependencies PC0->PC1->PC2
    vecs[6].dest[0] = 4'd4; vecs[6].r1[1] = 4'd4;
    vecs[6].dest[1] = 4'd5; vecs[6].r2[2] = 4'd5;
    vecs[6].exp_stall = 4; vecs[6].exp_edges = 10;
    // v7: single-instruction program
    vecs[7].last_pc = 4'd0; vecs[7].exp_issue = 1; vecs[7].exp_edges = 3;

    rst = 1'b0; start = 1'b0; halt = 1'b0;
    load_prog(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk); rst = 1'b1;

    // halt alone in IDLE does nothing
    halt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_halt_busy", 32'(busy), 0);
    chk("idle_halt_pc", 32'(PC), 0);

    // start together with halt in IDLE launches
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("start_halt_busy", 32'(busy), 1);
    @(negedge clk); start = 1'b0; halt = 1'b0;
    wait_done("start_halt");
    chk("start_halt_issue_cnt", 32'(issue_cnt), 4);

    for (int k = 0; k < 8; k++) run_vec(k);

    // reset while stalled abandons the run
    load_prog(vecs[1]);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_stall_bubble", 32'(bubble), 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("mid_reset");
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_pc", 32'(PC), 0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("restart_issue0", 32'(issue_valid), 1);
    chk("restart_pc1", 32'(PC), 1);
    @(posedge clk); #1;
    chk("restart_bubble", 32'(bubble), 1);
    wait_done("restart");
    chk("restart_stall_cnt", 32'(stall_cnt), 2);
    chk("restart_issue_cnt", 32'(issue_cnt), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
